// File: rtl/menu_vga_render_if.sv
// Menu/VGA render port bundle: menu state in, pixel colour, syncs and
// frame marker out. The renderer uses the slave view; the menu FSM / board
// side uses the master view.
interface menu_vga_render_if;
    logic [2:0]  menu_state;
    logic [11:0] RGB;
    logic        vga_h;
    logic        vga_v;
    logic        frame_start;

    modport master (
        output menu_state,
        input  RGB,
        input  vga_h,
        input  vga_v,
        input  frame_start
    );

    modport slave (
        input  menu_state,
        output RGB,
        output vga_h,
        output vga_v,
        output frame_start
    );
endinterface

// File: rtl/menu_vga_render.sv
// Menu / game-select screen renderer for a 640x480@60 Hz VGA output.
// A divide-by-CLK_DIV pixel enable on the system clock steps the raster
// counters; the menu state is shadowed once per frame so the picture never
// tears. Colour and sync are registered together one pixel after the counters.
// Geometry parameters default to the standard 640x480 timing and menu layout.
module menu_vga_render #(
    parameter int CLK_DIV    = 4,
    parameter int H_ACTIVE   = 640,
    parameter int H_SYNC_BEG = 656,
    parameter int H_SYNC_END = 751,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_SYNC_BEG = 490,
    parameter int V_SYNC_END = 491,
    parameter int V_TOTAL    = 525,
    parameter int BOX_X0     = 192,
    parameter int BOX_X1     = 447,
    parameter int BOX_Y0     = 64,
    parameter int BOX_H      = 64,
    parameter int BOX_PITCH  = 96
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    menu_vga_render_if.slave vga
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW    = $clog2(H_TOTAL);
    localparam int VW    = $clog2(V_TOTAL);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_SYNC_BEG);
    localparam logic [HW-1:0] HS_END = HW'(H_SYNC_END);
    localparam logic [HW-1:0] BX_LO  = HW'(BOX_X0);
    localparam logic [HW-1:0] BX_HI  = HW'(BOX_X1);

    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_SYNC_BEG);
    localparam logic [VW-1:0] VS_END = VW'(V_SYNC_END);

    // Box row bounds are elaboration-time constants; the decode is compare only.
    localparam logic [VW-1:0] BOX_T0 = VW'(BOX_Y0);
    localparam logic [VW-1:0] BOX_B0 = VW'(BOX_Y0 + BOX_H - 1);
    localparam logic [VW-1:0] BOX_T1 = VW'(BOX_Y0 + BOX_PITCH);
    localparam logic [VW-1:0] BOX_B1 = VW'(BOX_Y0 + BOX_PITCH + BOX_H - 1);
    localparam logic [VW-1:0] BOX_T2 = VW'(BOX_Y0 + 2 * BOX_PITCH);
    localparam logic [VW-1:0] BOX_B2 = VW'(BOX_Y0 + 2 * BOX_PITCH + BOX_H - 1);
    localparam logic [VW-1:0] BOX_T3 = VW'(BOX_Y0 + 3 * BOX_PITCH);
    localparam logic [VW-1:0] BOX_B3 = VW'(BOX_Y0 + 3 * BOX_PITCH + BOX_H - 1);

    localparam logic [11:0] COL_BLACK = 12'h000;
    localparam logic [11:0] COL_RED   = 12'hF00;
    localparam logic [11:0] COL_GREEN = 12'h0F0;
    localparam logic [11:0] COL_CYAN  = 12'h0FF;
    localparam logic [11:0] COL_BG    = 12'h00F;
    localparam logic [11:0] COL_SEL   = 12'hFF0;
    localparam logic [11:0] COL_BOX   = 12'h888;

    logic [DIV_W-1:0] div_q, div_d;
    logic             pix_en_s;
    logic [HW-1:0]    h_cnt_q, h_cnt_d;
    logic [VW-1:0]    v_cnt_q, v_cnt_d;
    logic             frame_end_s;
    logic [2:0]       shadow_q;
    logic             active_s;
    logic             box_x_s;
    logic             box_y_s;
    logic [1:0]       box_idx_s;
    logic [11:0]      rgb_q, rgb_d;
    logic             vga_h_q, vga_h_d;
    logic             vga_v_q, vga_v_d;
    logic             frame_start_q;

    assign pix_en_s    = (div_q == DIV_LAST);
    assign frame_end_s = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    assign active_s    = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    assign box_x_s     = (h_cnt_q >= BX_LO) && (h_cnt_q <= BX_HI);

    // Divider next state: count 0..CLK_DIV-1, wrapping on the pixel-enable cycle
    always_comb begin
        if (pix_en_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Raster counter next state: h wraps at end of line, v steps on each h wrap
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + VW'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + HW'(1);
        end
    end

    // Which menu item row (if any) the current line falls in
    always_comb begin
        box_y_s   = 1'b1;
        box_idx_s = 2'd0;
        if ((v_cnt_q >= BOX_T0) && (v_cnt_q <= BOX_B0)) begin
            box_idx_s = 2'd0;
        end else if ((v_cnt_q >= BOX_T1) && (v_cnt_q <= BOX_B1)) begin
            box_idx_s = 2'd1;
        end else if ((v_cnt_q >= BOX_T2) && (v_cnt_q <= BOX_B2)) begin
            box_idx_s = 2'd2;
        end else if ((v_cnt_q >= BOX_T3) && (v_cnt_q <= BOX_B3)) begin
            box_idx_s = 2'd3;
        end else begin
            box_y_s   = 1'b0;
            box_idx_s = 2'd0;
        end
    end

    // Pixel colour for the current counter position and shadowed menu state
    always_comb begin
        rgb_d = COL_BLACK;
        if (active_s) begin
            if (shadow_q[0]) begin
                case (shadow_q[2:1])
                    2'd0:    rgb_d = COL_RED;
                    2'd1:    rgb_d = COL_GREEN;
                    2'd2:    rgb_d = COL_CYAN;
                    2'd3:    rgb_d = COL_BLACK;
                    default: rgb_d = COL_BLACK;
                endcase
            end else if (box_x_s && box_y_s) begin
                if (box_idx_s == shadow_q[2:1]) begin
                    rgb_d = COL_SEL;
                end else begin
                    rgb_d = COL_BOX;
                end
            end else begin
                rgb_d = COL_BG;
            end
        end else begin
            rgb_d = COL_BLACK;
        end
    end

    // Active-low sync pulses decoded from the current counter position
    always_comb begin
        vga_h_d = ~((h_cnt_q >= HS_BEG) && (h_cnt_q <= HS_END));
        vga_v_d = ~((v_cnt_q >= VS_BEG) && (v_cnt_q <= VS_END));
    end

    // Pixel-enable divider register
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Raster counters, per-frame state shadow and frame marker
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            h_cnt_q       <= '0;
            v_cnt_q       <= '0;
            shadow_q      <= 3'd0;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            if (pix_en_s) begin
                h_cnt_q <= h_cnt_d;
                v_cnt_q <= v_cnt_d;
                if (frame_end_s) begin
                    shadow_q      <= vga.menu_state;
                    frame_start_q <= 1'b1;
                end
            end
        end
    end

    // Colour and syncs registered together so they stay pixel-aligned
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rgb_q   <= COL_BLACK;
            vga_h_q <= 1'b1;
            vga_v_q <= 1'b1;
        end else if (pix_en_s) begin
            rgb_q   <= rgb_d;
            vga_h_q <= vga_h_d;
            vga_v_q <= vga_v_d;
        end
    end

    assign vga.RGB         = rgb_q;
    assign vga.vga_h       = vga_h_q;
    assign vga.vga_v       = vga_v_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_menu_vga_render.sv
// Bench for menu_vga_render. Two instances share clock and reset: one with
// the standard 640x480 geometry (observed over its first lines: reset values,
// first hsync fall, line period and sync width) and one with a shrunken raster
// so that many whole frames fit in a short run (shadow loads, menu boxes,
// in-game fills, tear-free update, simultaneous load, mid-frame reset).
// Every cycle both instances are compared against a pixel-level model that
// maps (pixel number, latched state) to colour/sync using plain arithmetic.
module tb_menu_vga_render;
    typedef struct packed {
        int ha;  int hsb; int hse; int ht;
        int va;  int vsb; int vse; int vt;
        int bx0; int bx1; int by0; int bh; int pitch;
    } geom_t;

    localparam int S_HA = 28, S_HSB = 30, S_HSE = 33, S_HT = 36;
    localparam int S_VA = 24, S_VSB = 26, S_VSE = 27, S_VT = 28;
    localparam int S_BX0 = 8, S_BX1 = 23, S_BY0 = 2, S_BH = 3, S_PITCH = 5;
    localparam int DIV = 4;

    localparam geom_t G_S = '{S_HA, S_HSB, S_HSE, S_HT, S_VA, S_VSB, S_VSE, S_VT,
                              S_BX0, S_BX1, S_BY0, S_BH, S_PITCH};
    localparam geom_t G_D = '{640, 656, 751, 800, 480, 490, 491, 525, 192, 447, 64, 64, 96};

    localparam logic [14:0] RST_VAL = {12'h000, 1'b1, 1'b1, 1'b0};

    logic clk;
    logic rst_n;

    menu_vga_render_if vif_s ();
    menu_vga_render_if vif_d ();

    menu_vga_render #(
        .CLK_DIV(DIV),
        .H_ACTIVE(S_HA), .H_SYNC_BEG(S_HSB), .H_SYNC_END(S_HSE), .H_TOTAL(S_HT),
        .V_ACTIVE(S_VA), .V_SYNC_BEG(S_VSB), .V_SYNC_END(S_VSE), .V_TOTAL(S_VT),
        .BOX_X0(S_BX0), .BOX_X1(S_BX1), .BOX_Y0(S_BY0), .BOX_H(S_BH), .BOX_PITCH(S_PITCH)
    ) u_dut_s (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .vga      (vif_s)
    );

    menu_vga_render u_dut_d (
        .sys_clk  (clk),
        .sys_rst_n(rst_n),
        .vga      (vif_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_assert;
    int          n_fail;
    int          e;            // rising edges since reset release
    logic [2:0]  drv_state;
    logic [2:0]  shadow [2];   // state latched for the frame being drawn
    logic [14:0] exp_v [2];    // {RGB, vga_h, vga_v, frame_start}
    geom_t       g [2];

    // Colour of pixel (h,v) when the frame's latched state is s.
    function automatic logic [11:0] colour(int h, int v, int s, geom_t gm);
        int i;
        if (!(h < gm.ha && v < gm.va)) return 12'h000;
        case (s)
            1: return 12'hF00;
            3: return 12'h0F0;
            5: return 12'h0FF;
            7: return 12'h000;
            default: ;
        endcase
        if (h >= gm.bx0 && h <= gm.bx1 && v >= gm.by0) begin
            i = (v - gm.by0) / gm.pitch;
            if (i < 4 && ((v - gm.by0) % gm.pitch) < gm.bh)
                return (i == s / 2) ? 12'hFF0 : 12'h888;
        end
        return 12'h00F;
    endfunction

    // Outputs after pixel update number p (p >= 1) describe raster pixel p-1.
    function automatic logic [14:0] model_out(int p, logic [2:0] s, geom_t gm);
        int   q, h, v;
        logic hs, vs;
        q  = (p - 1) % (gm.ht * gm.vt);
        h  = q % gm.ht;
        v  = q / gm.ht;
        hs = !(h >= gm.hsb && h <= gm.hse);
        vs = !(v >= gm.vsb && v <= gm.vse);
        return {colour(h, v, int'(s), gm), hs, vs, 1'b0};
    endfunction

    function automatic int pos(int f, int v, int h);
        return DIV * (S_HT * S_VT * f + S_HT * v + h);
    endfunction

    task automatic check(input string tag, input logic [14:0] obs, input logic [14:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s edge=%0d observed rgb=%h h=%b v=%b fs=%b expected rgb=%h h=%b v=%b fs=%b",
                   tag, e, obs[14:3], obs[2], obs[1], obs[0],
                   expv[14:3], expv[2], expv[1], expv[0]);
        end
    endtask

    task automatic set_state(input logic [2:0] s);
        drv_state        = s;
        vif_s.menu_state = s;
        vif_d.menu_state = s;
    endtask

    task automatic reset_model();
        e = 0;
        for (int k = 0; k < 2; k++) begin
            shadow[k] = 3'd0;
            exp_v[k]  = RST_VAL;
        end
    endtask

    // One sys_clk: advance the model at the rising edge, compare at the falling edge.
    task automatic step();
        int p;
        @(posedge clk);
        if (rst_n) begin
            e = e + 1;
            for (int k = 0; k < 2; k++) begin
                if (e % DIV == 0) begin
                    p        = e / DIV;
                    exp_v[k] = model_out(p, shadow[k], g[k]);
                    if (p % (g[k].ht * g[k].vt) == 0) begin
                        shadow[k]   = drv_state;
                        exp_v[k][0] = 1'b1;
                    end
                end else begin
                    exp_v[k][0] = 1'b0;
                end
            end
        end
        @(negedge clk);
        check("scaled", {vif_s.RGB, vif_s.vga_h, vif_s.vga_v, vif_s.frame_start}, exp_v[0]);
        check("default", {vif_d.RGB, vif_d.vga_h, vif_d.vga_v, vif_d.frame_start}, exp_v[1]);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (e < target && guard < 200000) begin
            step();
            guard++;
        end
        n_assert++;
        assert (e == target) else begin
            n_fail++;
            $error("FAIL run_to observed edge=%0d expected edge=%0d", e, target);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_assert = 0;
        n_fail   = 0;
        g[0]     = G_S;
        g[1]     = G_D;
        set_state(3'd2);
        rst_n = 1'b1;
        reset_model();
        #1;
        rst_n = 1'b0;
        run(10);
        rst_n = 1'b1;

        // Frame 0 uses the reset shadow (game1 menu); frames 1..2 show state 2.
        run_to(pos(2, 0, 0));
        set_state(3'd5);                // frame 3: cyan fill
        run_to(pos(3, 0, 0));
        set_state(3'd7);                // frame 4: black fill
        run_to(pos(4, 0, 0));
        set_state(3'd0);                // frame 5: menu, box 0 selected
        run_to(pos(5, 14, 0));
        set_state(3'd6);                // mid-frame change: frame 6 shows box 3
        run_to(pos(6, 0, 0));

        // Random state changes at arbitrary times over three frames.
        while (e < pos(9, 0, 0) - 1) begin
            if ($urandom_range(0, 299) == 0) set_state(3'($urandom_range(0, 7)));
            step();
        end
        // Change in the very cycle of the shadow load: the new value is taken.
        set_state(3'd3);
        step();
        set_state(3'd4);
        run_to(pos(10, 15, 10));

        // Asynchronous mid-frame reset, checked before the next clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_scaled", {vif_s.RGB, vif_s.vga_h, vif_s.vga_v, vif_s.frame_start}, RST_VAL);
        check("async_rst_default", {vif_d.RGB, vif_d.vga_h, vif_d.vga_v, vif_d.frame_start}, RST_VAL);
        reset_model();
        run(10);
        rst_n = 1'b1;
        // First frame after release shows game1 (box 0), the next shows state 4.
        run_to(pos(2, 1, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/menu_vga_render.md
# menu_vga_render

Renders the menu/game-select screen onto a 640x480@60 Hz VGA output. It consumes the 3-bit menu state from the top-level menu FSM and produces `RGB`, `vga_h` and `vga_v` for the board connector. Pixel timing comes from an internal divide-by-4 pixel-enable on the single 100 MHz system clock, so no separate VGA clock is needed. The state is sampled once per frame so the picture never tears.

## Interface
- `CLK_DIV`, 4: sys_clk cycles per pixel; fixed at 4 for 100 MHz to 25 MHz.
- `sys_clk`  in  1  100 MHz system clock; every register is clocked on its rising edge.
- `sys_rst_n`  in  1  reset, asynchronous and active-low.
- `menu_state`  in  3  menu FSM state, encoded as:
  - 0 = game1, 1 = game1_in
  - 2 = game2, 3 = game2_in
  - 4 = game3, 5 = game3_in
  - 6 = exit, 7 = exit_in
- `RGB`  out  12  pixel colour, 4 bits each in the order R, G, B.
- `vga_h`  out  1  horizontal sync, active low.
- `vga_v`  out  1  vertical sync, active low.
- `frame_start`  out  1  one-sys_clk pulse when `menu_state` is latched.

## Operation
- **Pixel enable (`pix_en`)**
  - Driven by a 2-bit divider counting 0..3, with reset value 0.
  - `pix_en` is high only in the cycle where the divider equals 3.
  - All counters and outputs below update only on `pix_en` cycles.
- **Horizontal counter (`h_cnt`)**
  - Counts 0..799, then wraps to 0.
- **Vertical counter (`v_cnt`)**
  - Counts 0..524 and increments only when `h_cnt` wraps.
  - Wraps to 0 after 524.
  - Both counters reset to 0.
- **Sync decode**
  - `vga_h` is 0 while 656 <= h_cnt <= 751.
  - `vga_v` is 0 while 490 <= v_cnt <= 491.
- **Active area**
  - Active when h_cnt < 640 and v_cnt < 480.
  - Outside the active area, `RGB` = 0.
- **State shadow register**
  - Loads `menu_state` on the `pix_en` cycle with h_cnt = 799 and v_cnt = 524.
  - `frame_start` = 1 in that same cycle.
  - Reset value is 0 (game1).
  - Between loads, input changes are ignored.
- **Rendering, using the shadow value `s`; selected index k = s[2:1]**
  - If s[0] = 1 (in a game), the whole active area is filled with one colour:
    - 1 -> 12'hF00
    - 3 -> 12'h0F0
    - 5 -> 12'h0FF
    - 7 -> 12'h000
  - If s[0] = 0 (menu):
    - Background is 12'h00F.
    - Item box i (i = 0..3) covers 192 <= h <= 447 and 64+96i <= v <= 127+96i.
    - Box i is 12'hFF0 when i = k, otherwise 12'h888.
  - Box y-ranges are derived from v_cnt by compare only; no multipliers.
- **Output registration**
  - `RGB`, `vga_h` and `vga_v` are registered together on `pix_en` cycles.
  - They are computed from the pre-increment counter values.
  - Colour and sync therefore stay aligned, with a latency of one pixel.

## Timing
- **Reset values**
  - `RGB` = 0, `vga_h` = 1, `vga_v` = 1, `frame_start` = 0.
  - Divider, counters and shadow all = 0.
- **First update:** the first `pix_en` is the 4th rising edge after `sys_rst_n` deasserts.
- **Periods**
  - Pixel = 4 sys_clk.
  - Line = 800 pixels = 3200 sys_clk.
  - Frame = 525 lines = 1,680,000 sys_clk.
- **Pulse widths**
  - `vga_h` low for 96 pixels = 384 sys_clk per line.
  - `vga_v` low for 2 lines = 6400 sys_clk per frame.
- **Output latency:** the outputs seen after the edge at which the counters equal (h,v) describe pixel (h,v).
- **Input latency:** a change on `menu_state` appears from the next frame's pixel (0,0), at most one frame later.
- **Simultaneous events:** if `menu_state` changes in the same cycle as the shadow load, the new value is captured.
- **Reset mid-frame:** all outputs immediately return to their reset values (asynchronous), and the frame restarts at (0,0) on release.

## Test plan
- **Reset check:** hold `sys_rst_n` = 0 for 10 cycles, then release.
  - During reset, `RGB` = 0 and `vga_h` = `vga_v` = 1.
  - The first `vga_h` fall occurs 657 pixels (2628 sys_clk) after release.
- **Sync timing:** run 2 full frames.
  - `vga_h` period is 3200 sys_clk with a low width of 384.
  - `vga_v` period is 1,680,000 sys_clk with a low width of 6400.
  - `frame_start` fires exactly once per frame.
- **Menu render, state 2:** sample the pixel at h = 300, v = 200 (box 1) -> 12'hFF0.
  - Pixel h = 300, v = 100 (box 0) -> 12'h888.
  - Pixel h = 100, v = 100 -> 12'h00F.
  - Pixel h = 700, v = 100 -> 0.
- **In-game fill:** with `menu_state` = 5, every active pixel -> 12'h0FF.
  - With `menu_state` = 7, every active pixel -> 12'h000.
- **Tear-free update:** change `menu_state` from 0 to 6 at v = 240.
  - The rest of that frame still shows box 0 yellow.
  - The next frame shows box 3 (v = 352..415) yellow.
- **Reset mid-frame:** assert `sys_rst_n` = 0 at v = 300.
  - `RGB` drops to 0 and both syncs go to 1 asynchronously, without waiting for a clock edge.
  - After release, the shadow holds game1, so box 0 is yellow on the next frame.
